ps2_host_tx: RTL
================

# ps2_host_tx

PS/2 host-to-device transmitter. It sends one command byte, such as 0xF4 "enable data reporting" or 0xFF "reset", from the FPGA to a PS/2 mouse. It complements the existing device-to-host PS/2 receiver on the same `ps2ck`/`ps2dt` pins. It drives both lines open-collector through active-high pull-low enables, and owns the bus only while a transfer is in progress.

## Interface
- `INHIBIT_CYCLES`, default 5000. Clock cycles `ps2ck` is held low before the start bit (≥100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, default 750000. Maximum cycles allowed between consecutive device falling edges, and from clock release to the first falling edge (15 ms).
- `CLOCK`  in  1  system clock, all logic on rising edge.
- `RESETN`  in  1  reset, synchronous, active-low.
- `tx_data`  in  8  command byte, sampled when `tx_valid && tx_ready`.
- `tx_valid`  in  1  request to send `tx_data`.
- `tx_ready`  out  1  high only in IDLE; reset value 1.
- `tx_done`  out  1  one-cycle pulse on acknowledged completion; reset value 0.
- `tx_error`  out  1  one-cycle pulse on NACK or timeout; reset value 0.
- `ps2ck`  in  1  PS/2 clock line (raw, asynchronous).
- `ps2dt`  in  1  PS/2 data line (raw, asynchronous).
- `ps2ck_oe`  out  1  1 = pull clock line low; reset value 0.
- `ps2dt_oe`  out  1  1 = pull data line low; reset value 0.

## Operation
- `ps2ck` and `ps2dt` each pass through a 2-flop synchronizer.
- A falling edge (`fall`) is detected when the previous synced `ps2ck` is 1 and the current is 0.
- Shift frame is 11 bits: start 0, d0..d7 LSB first, odd parity (`~^tx_data`), stop 1.
- A 1 on the line is sent by releasing it (`oe`=0). A 0 is sent by `oe`=1.
- States:
  - IDLE: both `oe`=0, `tx_ready`=1. On accept, latch `tx_data`, clear the bit counter and delay counter, and go to INHIBIT.
  - INHIBIT: `ps2ck_oe`=1 for exactly `INHIBIT_CYCLES` cycles, then go to START.
  - START: `ps2ck_oe`=1 and `ps2dt_oe`=1 (start bit) for 1 cycle. Then `ps2ck_oe`=0, clear the timeout counter, and go to SEND.
  - SEND: on each `fall`, present the next bit. Falls 1..8 present d0..d7, fall 9 presents parity, fall 10 presents stop (`ps2dt_oe`=0). After fall 10, go to ACK.
  - ACK: on the next `fall`, sample synced `ps2dt`.
    - 0: go to WAIT_IDLE.
    - 1: NACK. Pulse `tx_error` and go to IDLE.
  - WAIT_IDLE: when synced `ps2ck` and `ps2dt` are both 1, pulse `tx_done` and go to IDLE.
- Timeout:
  - Applies in SEND, ACK and WAIT_IDLE.
  - The counter clears on every `fall` and increments otherwise.
  - On reaching `TIMEOUT_CYCLES`: both `oe`=0, pulse `tx_error`, go to IDLE.
- `tx_valid` outside IDLE is ignored. No queuing, and `tx_data` changes have no effect mid-transfer.
- `tx_done` and `tx_error` are never asserted in the same cycle.
- `RESETN`=0 in any state: on the next edge, state is IDLE, both `oe`=0, pulses are 0, and `tx_ready`=1. No `tx_error` is generated.

## Timing
- Accept at edge N:
  - N+1: `tx_ready`=0, `ps2ck_oe`=1.
  - N+1+`INHIBIT_CYCLES`: `ps2dt_oe`=1.
  - N+2+`INHIBIT_CYCLES`: `ps2ck_oe`=0.
- A raw `ps2ck` fall reaches `fall` after 2 synchronizer cycles. `ps2dt_oe` updates on the edge where `fall` is high, i.e. ≤3 cycles after the raw edge. This is well inside the ≥5 µs device low phase.
- `tx_done`/`tx_error` are high exactly one cycle. `tx_ready` returns to 1 in the following cycle.
- Back-to-back: a new accept is possible in the cycle `tx_ready` is 1.
- Counters are wide enough for each parameter value, with no wrap (`TIMEOUT_CYCLES` needs 20 bits).

## Test plan
- Reset: hold `RESETN`=0 during an active SEND. Required after one edge: `ps2ck_oe`=0, `ps2dt_oe`=0, `tx_ready`=1, `tx_done`=0, `tx_error`=0.
- Send 0xF4 to a device model (`INHIBIT_CYCLES`=20) clocking at 10 kHz:
  - Line sampled at device rising edges: 0 0 0 1 0 1 1 1 1 0 1 (start, d0..d7, parity 0, stop).
  - Model acks low, then releases the lines.
  - Required: exactly one `tx_done` pulse and no `tx_error`.
- Send 0xFF: parity bit is 1 (`ps2dt_oe`=0 after fall 9). Model drives ack=1 (NACK). Required: one `tx_error`, no `tx_done`, `tx_ready`=1 afterwards.
- Timeout (`TIMEOUT_CYCLES`=100), device never clocks. Required: `tx_error` exactly 100 cycles after `ps2ck_oe` falls, with both `oe`=0 in that cycle.
- Inhibit timing: accept at cycle N with `INHIBIT_CYCLES`=20. Required:
  - `ps2ck_oe` high for cycles N+1..N+21.
  - `ps2dt_oe` rises at N+21.
- `tx_valid`=1 with `tx_data`=0xAA during an 0xF4 transfer: frame bits unchanged, and only one `tx_done` in total.

Source files
------------

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       CLOCK,
    input  logic       RESETN,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2ck,
    input  logic       ps2dt,
    output logic       ps2ck_oe,
    output logic       ps2dt_oe
);

    localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES + 1) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    // Terminal counts: a counter that has seen N-1 full cycles ends its Nth cycle here.
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        SEND,
        ACK,
        WAIT_IDLE
    } state_t;

    // Line synchronizers; reset to 1 so a released bus never looks like a falling edge.
    logic ck_meta_q, ck_sync_q, ck_prev_q;
    logic dt_meta_q, dt_sync_q;
    logic fall;

    state_t           state_q, state_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             ck_oe_q, ck_oe_d;
    logic             dt_oe_q, dt_oe_d;
    // Remaining frame bits after the start bit: {stop, parity, d7..d0}, sent LSB first.
    logic [9:0]       shift_q, shift_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [INH_W-1:0] delay_cnt_q, delay_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             to_expired;

    // Two-flop synchronizers plus one history flop for clock edge detection
    always_ff @(posedge CLOCK) begin
        if (!RESETN) begin
            ck_meta_q <= 1'b1;
            ck_sync_q <= 1'b1;
            ck_prev_q <= 1'b1;
            dt_meta_q <= 1'b1;
            dt_sync_q <= 1'b1;
        end else begin
            ck_meta_q <= ps2ck;
            ck_sync_q <= ck_meta_q;
            ck_prev_q <= ck_sync_q;
            dt_meta_q <= ps2dt;
            dt_sync_q <= dt_meta_q;
        end
    end

    assign fall = ck_prev_q & ~ck_sync_q;

    // Next-state, counter and output computation for the transfer sequencer
    always_comb begin
        state_d     = state_q;
        ready_d     = ready_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        ck_oe_d     = ck_oe_q;
        dt_oe_d     = dt_oe_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        delay_cnt_d = delay_cnt_q;
        to_cnt_d    = to_cnt_q;
        to_expired  = 1'b0;

        // Device watchdog: every device clock fall restarts the window.
        if (state_q == SEND || state_q == ACK || state_q == WAIT_IDLE) begin
            if (fall) begin
                to_cnt_d = '0;
            end else if (to_cnt_q == TO_LAST) begin
                to_expired = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                ck_oe_d = 1'b0;
                dt_oe_d = 1'b0;
                // Ready comes back one cycle after a done/error pulse.
                ready_d = 1'b1;
                if (tx_valid && ready_q) begin
                    shift_d     = {1'b1, ~^tx_data, tx_data};
                    bit_cnt_d   = '0;
                    delay_cnt_d = '0;
                    ready_d     = 1'b0;
                    ck_oe_d     = 1'b1;
                    state_d     = INHIBIT;
                end
            end

            INHIBIT: begin
                // Clock held low to claim the bus from the device.
                if (delay_cnt_q == INH_LAST) begin
                    dt_oe_d = 1'b1;
                    state_d = START;
                end else begin
                    delay_cnt_d = delay_cnt_q + INH_W'(1);
                end
            end

            START: begin
                // Data stays low as the start bit; releasing clock hands clocking to the device.
                ck_oe_d  = 1'b0;
                to_cnt_d = '0;
                state_d  = SEND;
            end

            SEND: begin
                if (to_expired) begin
                    ck_oe_d = 1'b0;
                    dt_oe_d = 1'b0;
                    error_d = 1'b1;
                    state_d = IDLE;
                end else if (fall) begin
                    dt_oe_d   = ~shift_q[0];
                    shift_d   = {1'b1, shift_q[9:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = ACK;
                    end
                end
            end

            ACK: begin
                if (to_expired) begin
                    ck_oe_d = 1'b0;
                    dt_oe_d = 1'b0;
                    error_d = 1'b1;
                    state_d = IDLE;
                end else if (fall) begin
                    if (!dt_sync_q) begin
                        state_d = WAIT_IDLE;
                    end else begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end
                end
            end

            WAIT_IDLE: begin
                // A returned-to-idle bus wins over a coincident timeout.
                if (ck_sync_q && dt_sync_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (to_expired) begin
                    ck_oe_d = 1'b0;
                    dt_oe_d = 1'b0;
                    error_d = 1'b1;
                    state_d = IDLE;
                end
            end

            default: begin
                ck_oe_d = 1'b0;
                dt_oe_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state and registered outputs
    always_ff @(posedge CLOCK) begin
        if (!RESETN) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            ck_oe_q     <= 1'b0;
            dt_oe_q     <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            delay_cnt_q <= '0;
            to_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            error_q     <= error_d;
            ck_oe_q     <= ck_oe_d;
            dt_oe_q     <= dt_oe_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            delay_cnt_q <= delay_cnt_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    assign tx_ready = ready_q;
    assign tx_done  = done_q;
    assign tx_error = error_q;
    assign ps2ck_oe = ck_oe_q;
    assign ps2dt_oe = dt_oe_q;

endmodule
